// File: rtl/pipe_stage.sv
// pipe_stage: parametrised register stage between two processor pipeline
// stages with a valid/ready handshake, optional two-entry skid buffer,
// synchronous flush (bubble insertion) and saturating occupancy counters.
// An empty stage always presents all-zero data so downstream decode sees a NOP.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       upstream handshake, in_data payload (lane 0 at LSBs)
//   out_valid/out_ready     downstream handshake, out_data payload
//   flush                   synchronous squash of held and incoming entries
//   cnt_clr                 synchronous clear of both counters
//   stall_cnt               cycles with out_valid=1 and out_ready=0
//   bubble_cnt              cycles with out_valid=0 and out_ready=1
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_EMPTY | nothing held, out_data is zero
// ST_FULL  | main register holds the head entry
// ST_SKIDF | main holds the head, skid holds the next entry (SKID=1)
module pipe_stage #(
  parameter int WIDTH = 32,
  parameter int LANES = 6,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   flush,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);

  localparam int DW = LANES * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKIDF = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          accept;
  logic          pop;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid_ready
      // Registered ready: low exactly while both entries are occupied.
      logic rdy_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_d != ST_SKIDF);
        end
      end
      assign in_ready = rdy_q;
    end else begin : g_comb_ready
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any accept this cycle is discarded; a pop still completes downstream.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          // Without the skid buffer, accept while FULL implies pop, so the
          // skid branch is only reachable when SKID=1.
          if (accept && !pop && (SKID != 0)) begin
            state_d = ST_SKIDF;
            skid_d  = in_data;
          end else if (accept && pop) begin
            main_d = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_SKIDF: begin
          if (pop) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Counters ignore flush; clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (cnt_clr) begin
        bubble_cnt <= '0;
      end else if (!out_valid && out_ready && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: drives two pipe_stage instances with identical inputs --
// one with the skid buffer (SKID=1, CNT_W=16) and one without (SKID=0,
// CNT_W=4) -- and checks both every cycle against a small FIFO model
// (capacity 2 or 1) plus a few hand-computed expectations.
module tb_pipe_stage;

  localparam int WIDTH = 32;
  localparam int LANES = 6;
  localparam int DW    = WIDTH * LANES;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          flush;
  logic          cnt_clr;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [15:0]   s_stall, s_bubble;

  logic          n_in_ready, n_out_valid;
  logic [DW-1:0] n_out_data;
  logic [3:0]    n_stall, n_bubble;

  int n_vec;
  int n_err;

  // Reference model: index 0 = skid stage, 1 = plain stage.
  logic [DW-1:0] m_ent [2][2];
  int            m_cnt [2];
  int            m_st  [2];
  int            m_bc  [2];
  int            m_max [2];

  pipe_stage #(.WIDTH(WIDTH), .LANES(LANES), .SKID(1), .CNT_W(16)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_data    (in_data),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_data   (s_out_data),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .stall_cnt  (s_stall),
    .bubble_cnt (s_bubble)
  );

  pipe_stage #(.WIDTH(WIDTH), .LANES(LANES), .SKID(0), .CNT_W(4)) u_noskid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (n_in_ready),
    .in_data    (in_data),
    .out_valid  (n_out_valid),
    .out_ready  (out_ready),
    .out_data   (n_out_data),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .stall_cnt  (n_stall),
    .bubble_cnt (n_bubble)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the falling edge: compare outputs with the model, then advance
  // the model to what the coming rising edge must produce.
  task automatic model_cycle();
    logic          av [2];
    logic          ar [2];
    logic [DW-1:0] ad [2];
    int            ast [2];
    int            abc [2];
    av[0] = s_out_valid;  av[1] = n_out_valid;
    ar[0] = s_in_ready;   ar[1] = n_in_ready;
    ad[0] = s_out_data;   ad[1] = n_out_data;
    ast[0] = int'(s_stall);  ast[1] = int'(n_stall);
    abc[0] = int'(s_bubble); abc[1] = int'(n_bubble);
    for (int m = 0; m < 2; m++) begin
      string         nm;
      logic          e_valid;
      logic          e_ready;
      logic [DW-1:0] e_data;
      logic          pop;
      logic          acc;
      nm = (m == 0) ? "skid" : "noskid";
      if (!rst_n) begin
        m_cnt[m] = 0;
        m_st[m]  = 0;
        m_bc[m]  = 0;
      end
      e_valid = (m_cnt[m] > 0);
      e_data  = e_valid ? m_ent[m][0] : '0;
      e_ready = (m == 0) ? (m_cnt[m] < 2) : ((m_cnt[m] == 0) || out_ready);
      chk({nm, " out_valid"}, DW'(av[m]), DW'(e_valid));
      chk({nm, " out_data"}, ad[m], e_data);
      chk({nm, " in_ready"}, DW'(ar[m]), DW'(e_ready));
      chk({nm, " stall_cnt"}, DW'(ast[m]), DW'(m_st[m]));
      chk({nm, " bubble_cnt"}, DW'(abc[m]), DW'(m_bc[m]));
      if (rst_n) begin
        pop = e_valid && out_ready;
        acc = in_valid && e_ready;
        if (cnt_clr) m_st[m] = 0;
        else if (e_valid && !out_ready && m_st[m] < m_max[m]) m_st[m]++;
        if (cnt_clr) m_bc[m] = 0;
        else if (!e_valid && out_ready && m_bc[m] < m_max[m]) m_bc[m]++;
        if (flush) begin
          m_cnt[m] = 0;
        end else begin
          if (pop) begin
            m_ent[m][0] = m_ent[m][1];
            m_cnt[m]--;
          end
          if (acc) begin
            m_ent[m][m_cnt[m]] = in_data;
            m_cnt[m]++;
          end
        end
      end
    end
  endtask

  // Leaves the caller at 1 time unit after the next rising edge.
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_max[0] = 65535;
    m_max[1] = 15;
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0;
      m_st[m]  = 0;
      m_bc[m]  = 0;
      m_ent[m][0] = '0;
      m_ent[m][1] = '0;
    end
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) step();

    // Stream 0x11..0x16 with out_ready high: one-cycle latency, in order.
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = DW'(8'h11);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 5) in_data = DW'(8'h12 + i);
      else in_valid = 1'b0;
      chk("stream skid", s_out_data, DW'(8'h11 + i));
      chk("stream noskid", n_out_data, DW'(8'h11 + i));
    end
    chk("stream skid bubble", DW'(s_bubble), DW'(1));
    chk("stream noskid bubble", DW'(n_bubble), DW'(1));
    repeat (2) step();

    // Skid fill: 0xA in main, 0xB in skid, 0xC refused until release.
    cnt_clr = 1'b1;
    step();
    cnt_clr   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = DW'(8'h0A);
    step();
    in_data = DW'(8'h0B);
    step();
    in_data = DW'(8'h0C);
    step();
    step();
    chk("skidf in_ready", DW'(s_in_ready), '0);
    chk("skidf head", s_out_data, DW'(8'h0A));
    chk("noskid stalled ready", DW'(n_in_ready), '0);
    out_ready = 1'b1;
    step();
    chk("skid release head", s_out_data, DW'(8'h0B));
    chk("skid release ready", DW'(s_in_ready), DW'(1));
    chk("skid stall_cnt", DW'(s_stall), DW'(3));
    step();
    chk("skid third", s_out_data, DW'(8'h0C));
    in_valid = 1'b0;
    repeat (2) step();

    // Flush while SKIDF with 0xD offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(8'h01);
    step();
    in_data = DW'(8'h02);
    step();
    in_data = DW'(8'h0D);
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush skid valid", DW'(s_out_valid), '0);
    chk("flush skid data", s_out_data, '0);
    chk("flush skid ready", DW'(s_in_ready), DW'(1));
    chk("flush noskid valid", DW'(n_out_valid), '0);
    out_ready = 1'b1;
    repeat (3) step();

    // Plain stage: in_ready follows out_ready combinationally while full.
    in_valid = 1'b1;
    in_data  = DW'(8'h01);
    step();
    chk("noskid first", n_out_data, DW'(8'h01));
    in_data   = DW'(8'h02);
    out_ready = 1'b0;
    #1;
    chk("noskid ready follows 0", DW'(n_in_ready), '0);
    step();
    chk("noskid held", n_out_data, DW'(8'h01));
    out_ready = 1'b1;
    #1;
    chk("noskid ready follows 1", DW'(n_in_ready), DW'(1));
    step();
    chk("noskid second", n_out_data, DW'(8'h02));
    in_data = DW'(8'h03);
    step();
    chk("noskid third", n_out_data, DW'(8'h03));
    in_valid = 1'b0;
    repeat (3) step();

    // Saturation: 20 stalled cycles, 4-bit counter stops at 15.
    cnt_clr   = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'(8'h55);
    out_ready = 1'b0;
    step();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    repeat (20) step();
    chk("sat noskid stall", DW'(n_stall), DW'(15));
    chk("sat skid stall", DW'(s_stall), DW'(20));
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr skid stall", DW'(s_stall), '0);
    chk("clr noskid stall", DW'(n_stall), '0);

    // Asynchronous reset between edges while FULL.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst skid valid", DW'(s_out_valid), '0);
    chk("arst skid data", s_out_data, '0);
    chk("arst skid stall", DW'(s_stall), '0);
    chk("arst skid ready", DW'(s_in_ready), DW'(1));
    chk("arst noskid valid", DW'(n_out_valid), '0);
    chk("arst noskid data", n_out_data, '0);
    chk("arst noskid ready", DW'(n_in_ready), DW'(1));
    step();
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = DW'(8'h77);
    step();
    chk("post-reset skid", s_out_data, DW'(8'h77));
    chk("post-reset noskid", n_out_data, DW'(8'h77));

    // Randomised traffic, with periodic stretches of continuous out_ready.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = ((i % 500) < 100) ? 1'b1 : (($urandom % 3) != 0);
      flush     = ($urandom % 20) == 0;
      cnt_clr   = ($urandom % 64) == 0;
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    cnt_clr  = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
